// File: rtl/leaf_port_fifo.sv
// leaf_port_fifo: show-ahead circular FIFO carrying {dest_addr, data} entries,
// rejecting writes when full and counting the drops.
module leaf_port_fifo #(
   parameter int DWIDTH     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DWIDTH-1:0]             in_data,
   input  logic [ADDR_W-1:0]             in_dest_addr,
   input  logic                          in_valid,
   output logic [DWIDTH-1:0]             out_data,
   output logic [ADDR_W-1:0]             out_dest_addr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    drop_count,
   output logic                          drop_pulse
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + DWIDTH;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    drop_count_q, drop_count_d;
   logic          drop_pulse_q, drop_pulse_d;
   logic          push, pop, reject;

   // Full is judged on the registered count, so a pop never frees room for a same-cycle push.
   always_comb begin
      fifo_full    = count_q == FULL_CNT;
      fifo_empty   = count_q == '0;
      out_valid    = !fifo_empty;
      push         = in_valid && !fifo_full;
      reject       = in_valid && fifo_full;
      pop          = out_valid && out_ready;
      wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d      = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
      drop_count_d = (reject && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
      drop_pulse_d = reject;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_count_q <= drop_count_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wr_ptr_q] <= {in_dest_addr, in_data};
   end

   assign {out_dest_addr, out_data} = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign drop_count = drop_count_q;
   assign drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_leaf_port_fifo.sv
// tb_leaf_port_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations and random traffic.
module tb_leaf_port_fifo;
   localparam int DW = 16;
   localparam int DEPTH = 8;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [AW-1:0] in_dest_addr;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_dest_addr;
   logic          out_valid, fifo_full, fifo_empty, drop_pulse;
   logic [3:0]    fifo_count;
   logic [7:0]    drop_count;

   int n_checks = 0;
   int n_fail = 0;
   logic [AW+DW-1:0] q[$];
   int m_drop = 0;
   bit m_pulse = 0;
   bit chk_en = 0;

   leaf_port_fifo #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_dest_addr(in_dest_addr),
      .in_valid(in_valid), .out_data(out_data), .out_dest_addr(out_dest_addr),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_count(fifo_count), .drop_count(drop_count),
      .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the queue model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("count", fifo_count, q.size());
         check("empty", fifo_empty, q.size() == 0);
         check("full", fifo_full, q.size() == DEPTH);
         check("valid", out_valid, q.size() != 0);
         check("drop_count", drop_count, m_drop);
         check("drop_pulse", drop_pulse, m_pulse);
         if (q.size() != 0) begin
            check("head_data", out_data, q[0][DW-1:0]);
            check("head_dest", out_dest_addr, q[0][AW+DW-1:DW]);
         end
      end
   end

   task automatic step(input logic v, input logic r, input logic rst,
                       input logic [DW-1:0] d, input logic [AW-1:0] a);
      bit full;
      in_valid = v; out_ready = r; reset = rst; in_data = d; in_dest_addr = a;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_drop = 0;
         m_pulse = 0;
      end else begin
         full = q.size() == DEPTH;
         if (r && q.size() != 0) void'(q.pop_front());
         if (v && !full) q.push_back({a, d});
         if (v && full && m_drop < 255) m_drop++;
         m_pulse = v && full;
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      step(1'b0, r, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1, '0, '0);
   endtask

   initial begin
      do_reset();
      do_reset();
      chk_en = 1;
      check("rst_count", fifo_count, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_valid", out_valid, 0);
      check("rst_drop", drop_count, 0);
      check("rst_pulse", drop_pulse, 0);

      // basic ordering
      step(1, 0, 0, 16'h0011, 6'h05);
      check("b_nobypass", out_valid, 1);
      step(1, 0, 0, 16'h0022, 6'h21);
      step(1, 0, 0, 16'h0033, 6'h3F);
      check("b_count", fifo_count, 3);
      check("b_data", out_data, 16'h0011);
      check("b_dest", out_dest_addr, 6'h05);
      idle(1);
      check("b_pop1", out_data, 16'h0022);
      idle(1);
      check("b_pop2", out_data, 16'h0033);
      check("b_pop2d", out_dest_addr, 6'h3F);
      idle(1);
      check("b_empty", fifo_empty, 1);
      idle(1);
      check("b_underflow", fifo_count, 0);

      // fill and overflow
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 16'h1000 + 16'(i), AW'(i));
         if (i == 7) check("o_full", fifo_full, 1);
         if (i == 8) check("o_drop1", drop_count, 1);
      end
      check("o_drop2", drop_count, 2);
      check("o_pulse", drop_pulse, 1);
      check("o_head", out_data, 16'h1000);
      idle(0);
      check("o_pulse_off", drop_pulse, 0);

      // full plus simultaneous push and pop
      step(1, 1, 0, 16'hBEEF, 6'h2A);
      check("fp_count", fifo_count, 7);
      check("fp_drop", drop_count, 3);
      check("fp_head", out_data, 16'h1001);
      for (int i = 0; i < 7; i++) begin
         if (out_valid) check("fp_nobeef", out_data == 16'hBEEF, 0);
         idle(1);
      end
      check("fp_empty", fifo_empty, 1);

      // wrap-around at count 4
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0200 + 16'(i), AW'(i));
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 0, 16'h0300 + 16'(i), AW'(i + 4));
         check("w_count", fifo_count, 4);
      end
      check("w_head", out_data, 16'h0310);

      // drop saturation
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 0, 16'(i), AW'(i));
      for (int i = 0; i < 300; i++) step(1, 0, 0, 16'h7777, 6'h01);
      check("s_drop", drop_count, 255);
      idle(0);
      check("s_hold", drop_count, 255);
      check("s_pulse", drop_pulse, 0);

      // reset mid-operation
      do_reset();
      for (int i = 0; i < 11; i++) step(1, 0, 0, 16'h0400 + 16'(i), AW'(i));
      for (int i = 0; i < 3; i++) idle(1);
      check("r_count5", fifo_count, 5);
      check("r_drop3", drop_count, 3);
      step(1, 1, 1, 16'hDEAD, 6'h3E);
      check("r_count0", fifo_count, 0);
      check("r_drop0", drop_count, 0);
      check("r_valid0", out_valid, 0);
      step(1, 0, 0, 16'hABCD, 6'h11);
      check("r_count1", fifo_count, 1);
      check("r_head", out_data, 16'hABCD);
      check("r_headd", out_dest_addr, 6'h11);
      idle(1);
      check("r_empty", fifo_empty, 1);

      // random traffic with varying load
      for (int p = 0; p < 4; p++) begin
         int pv, pr;
         pv = (p == 0) ? 80 : (p == 1) ? 50 : (p == 2) ? 20 : 95;
         pr = (p == 0) ? 30 : (p == 1) ? 50 : (p == 2) ? 80 : 5;
         for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
                 $urandom_range(0, 299) == 0, 16'($urandom), AW'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/leaf_port_fifo.md
LEAF_PORT_FIFO -- requirements
Module: leaf_port_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, the payload data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the entry count; it must be a power of two and at least 2.
REQ-003 SHALL have parameter ADDR_W, default 6, the destination-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port in_data, input, DWIDTH bits: payload from the GPU or spine link.
REQ-007 SHALL have port in_dest_addr, input, ADDR_W bits: destination address travelling with the payload.
REQ-008 SHALL have port in_valid, input, 1 bit: a write request; the source has no backpressure.
REQ-009 SHALL have port out_data, output, DWIDTH bits: payload at the head entry, fed to the router data input.
REQ-010 SHALL have port out_dest_addr, output, ADDR_W bits: destination address at the head entry.
REQ-011 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the router consumes the head this cycle.
REQ-013 SHALL have port fifo_full, output, 1 bit: high when count == FIFO_DEPTH.
REQ-014 SHALL have port fifo_empty, output, 1 bit: high when count == 0.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-016 SHALL have port drop_count, output, 8 bits: saturating count of writes rejected while full.
REQ-017 SHALL have port drop_pulse, output, 1 bit: registered one-cycle flag set in the cycle after a rejected write.

Function
REQ-018 SHALL store {in_dest_addr, in_data} as one entry.
REQ-019 SHALL use a circular buffer with write and read pointers of $clog2(FIFO_DEPTH) bits and a separate occupancy counter.
REQ-020 SHALL accept a push when in_valid=1 and fifo_full=0, and no other push condition exists.
REQ-021 SHALL make a push visible at the outputs one cycle after the write edge: out_valid and the new count appear on the next cycle.
REQ-022 SHALL perform a pop when out_valid=1 and out_ready=1.
REQ-023 SHALL ignore out_ready while the FIFO is empty: no pointer change and no underflow.
REQ-024 SHALL present the head entry show-ahead: out_data and out_dest_addr equal mem[rd_ptr] whenever out_valid=1.
REQ-025 SHALL keep out_valid equal to NOT fifo_empty.
REQ-026 SHALL advance both pointers on a simultaneous push and pop with count unchanged; when not full, both operations complete in the same cycle.
REQ-027 SHALL reject a push when full even if a pop occurs in the same cycle (no full-bypass): count becomes FIFO_DEPTH-1 and the drop is recorded.
REQ-028 SHALL not bypass an empty FIFO: a push into an empty FIFO keeps out_valid=0 that cycle and is readable on the next cycle.
REQ-029 SHALL wrap both pointers from FIFO_DEPTH-1 to 0.
REQ-030 SHALL keep fifo_count in the range 0..FIFO_DEPTH at all times.
REQ-031 SHALL increment drop_count by 1 per rejected write, saturating at 255 and holding there.
REQ-032 SHALL set drop_pulse to 1 for exactly one cycle after each rejected write, and hold it at 1 across back-to-back rejected writes.
REQ-033 SHALL define out_data and out_dest_addr as don't-care while out_valid=0; the bench shall not check them then.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, clear both pointers, the counter, drop_count and drop_pulse.
REQ-035 SHALL hold these reset values after that edge: fifo_empty=1, fifo_full=0, out_valid=0, fifo_count=0, drop_count=0, drop_pulse=0.
REQ-036 SHALL not require memory contents to be cleared.
REQ-037 SHALL discard all stored entries when reset is asserted mid-operation.
REQ-038 SHALL give reset priority over any simultaneous push or pop: a push or pop in a reset cycle has no effect.

Verification
REQ-039 SHALL cover basic ordering: after reset, push 3 entries (data 0x0011/0x0022/0x0033, dest 6'h05/6'h21/6'h3F), out_ready=0 -> count=3, out_data=0x0011, out_dest_addr=6'h05; then out_ready=1 for 3 cycles -> entries pop in order, fifo_empty=1 afterwards.
REQ-040 SHALL cover fill and overflow: push 10 consecutive entries with out_ready=0 (FIFO_DEPTH=8) -> fifo_full=1 after 8 pushes, drop_count=2, drop_pulse high for 2 cycles, head still holds the first entry.
REQ-041 SHALL cover full plus simultaneous push and pop: with the FIFO full, in_valid=1 and out_ready=1 -> count=7, drop_count increments by 1, the pushed data never appears at the output.
REQ-042 SHALL cover wrap-around: 20 cycles of continuous push and pop at count=4 -> count stays 4 and the output sequence matches the input sequence delayed by 4 entries across pointer wrap.
REQ-043 SHALL cover drop saturation: 300 writes while full -> drop_count=255 and holds.
REQ-044 SHALL cover reset mid-operation: with count=5 and drop_count=3, assert reset one cycle with in_valid=1 -> count=0, drop_count=0, out_valid=0, and the next push is the sole head.
